data_format_in: RTL and testbench
=================================

// Module: data_format_in
// PURPOSE
//  Write-path width packer for the DDR2 FIFO datapath. Packs narrow DI_WIDTH samples
//  (data_in/din_vd) into DO_WIDTH words for the 64-bit DDR2 write FIFO.
//  It is the mirror of the read-side formatter. Words are emitted one cycle after the
//  last lane fills. flush forces out a partial word with a lane mask.
// PARAMETERS
//  DI_WIDTH   32   input sample width
//  DO_WIDTH   64   output word width; must be an integer multiple of DI_WIDTH
//  RATIO      DO_WIDTH/DI_WIDTH (localparam, >=2)   lanes per output word
//  IDX_W      clog2(RATIO) (localparam, >=1)   lane-index width
// PORTS
//  clk        in   1         single clock, all logic rising edge
//  reset      in   1         synchronous, active-high
//  data_in    in   DI_WIDTH  input sample
//  din_vd     in   1         data_in valid, may be high every cycle, no backpressure
//  flush      in   1         emit pending partial word (single-cycle pulse or level)
//  data_out   out  DO_WIDTH  packed word (registered)
//  dout_vd    out  1         data_out valid, one cycle per word
//  dout_mask  out  RATIO     bit i = lane i holds a real sample
//  word_cnt   out  32        count of words emitted (full and partial)
//  busy       out  1         high while a partial word is held (state FILLING)
// BEHAVIOUR
//  Reset (synchronous): data_out=0, dout_vd=0, dout_mask=0, word_cnt=0, busy=0,
//    lane idx=0, accumulator=0, state=EMPTY. A partial word held at reset is discarded.
//  States: EMPTY (idx==0, nothing held) and FILLING (1..RATIO-1 lanes held).
//  On din_vd: data_in goes to lane idx (lane i = bits [i*DI_WIDTH +: DI_WIDTH]),
//    then idx increments.
//    - idx==RATIO-1 when din_vd is high: the next cycle drives data_out = full word,
//      dout_vd=1, dout_mask = all ones. idx, accumulator and state -> EMPTY.
//    - Otherwise: state goes to (or stays in) FILLING.
//  flush in FILLING, no din_vd: the next cycle drives the partial word. Unfilled lanes
//    are zero, dout_mask has ones for lanes 0..idx-1. Then state -> EMPTY.
//  flush with din_vd in the same cycle: the sample is packed first.
//    - If that fills the word, exactly one full word is emitted.
//    - Otherwise, one partial word that includes the sample is emitted.
//  flush in EMPTY with no din_vd: no output, no state change. A level-high flush
//    therefore never produces empty words.
//  Latency: the final contributing sample (or flush) at cycle N gives dout_vd at N+1.
//  Throughput: one sample per cycle is sustained. dout_vd is never high on two
//    consecutive cycles when flush is unused.
//  When dout_vd=0, data_out and dout_mask hold their last values.
//    dout_vd is the only qualifier.
//  word_cnt increments on every dout_vd and wraps 2^32-1 -> 0.
//  busy = (state==FILLING), registered.
// CONFIGURATION
//  DATA_FORMAT_IN_MSB_FIRST_EN defined:
//    - The first sample of a word lands in the top lane (lane RATIO-1) and fills
//      downward. dout_mask bits follow the physical lane positions.
//    - A partial word occupies the upper lanes.
//  Undefined (default):
//    - LSB-first, as described above, which matches the read-side unpack order.
// STRUCTURE
//  Shared include ddr2_fifo_defs.vh (used by the read and write formatters) holds:
//    - DDR2 data width 64 and the sample width 32
//    - the 1-bit state encodings ST_EMPTY / ST_FILLING
//    - a clog2 constant function
//  No sub-module: accumulator, lane counter and output register stay inline,
//    in one always block per register group.
// TESTING
//  1 Reset, then din_vd 2 cycles with 0x11111111, 0x22222222 -> one cycle later
//    data_out=0x22222222_11111111, dout_vd=1, mask=2'b11, word_cnt=1.
//  2 din_vd held 8 cycles, incrementing data -> 4 words, dout_vd every other cycle,
//    no lost or duplicated sample, word_cnt=4.
//  3 One sample 0xAAAA5555, then flush alone -> data_out=0x00000000_AAAA5555,
//    mask=2'b01, busy falls 1->0.
//  4 flush with the second sample 0xBEEF0002 in the same cycle -> single full word
//    0xBEEF0002_<first>, mask=2'b11, no extra partial word. A flush pulse while EMPTY
//    -> no dout_vd.
//  5 reset asserted while FILLING -> all outputs 0. The next two samples 0x1, 0x2
//    -> 0x00000002_00000001 (the stale lane is discarded).
//  6 Preload word_cnt to 0xFFFFFFFF via 2^32 words or a forced state, emit one word
//    -> word_cnt=0. With DATA_FORMAT_IN_MSB_FIRST_EN, repeat test 1
//    -> 0x11111111_22222222.

Source files
------------

// File: rtl/data_format_in_pkg.sv
// Shared definitions for the DDR2 FIFO read/write formatters:
// datapath widths, the 1-bit formatter state encoding and a clog2 helper.
package data_format_in_pkg;

  localparam int DDR2_DATA_W = 64;
  localparam int SAMPLE_W    = 32;
  localparam int WORD_CNT_W  = 32;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_FILLING = 1'b1
  } fmt_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/data_format_in.sv
// Write-path width packer for the DDR2 FIFO datapath.
// Packs DI_WIDTH samples into DO_WIDTH words; flush pushes out a partial
// word together with a lane mask.
//
// Build option: DATA_FORMAT_IN_MSB_FIRST_EN
//   defined   - first sample of a word lands in the top lane and fills downward;
//               a partial word occupies the upper lanes.
//   undefined - LSB-first, matching the read-side unpack order.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_EMPTY   | idx == 0, no sample held
// ST_FILLING | 1..RATIO-1 lanes held in the accumulator
module data_format_in
  import data_format_in_pkg::*;
#(
  parameter int DI_WIDTH = SAMPLE_W,
  parameter int DO_WIDTH = DDR2_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DI_WIDTH-1:0]   data_in,
  input  logic                  din_vd,
  input  logic                  flush,
  output logic [DO_WIDTH-1:0]   data_out,
  output logic                  dout_vd,
  output logic [DO_WIDTH/DI_WIDTH-1:0] dout_mask,
  output logic [WORD_CNT_W-1:0] word_cnt,
  output logic                  busy
);

  localparam int RATIO = DO_WIDTH / DI_WIDTH;
  localparam int IDX_W = (clog2(RATIO) < 1) ? 1 : clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  fmt_state_e            state_q, state_next;
  logic [IDX_W-1:0]      idx_q, idx_next;
  logic [DO_WIDTH-1:0]   acc_q, acc_next, acc_fill;
  logic [IDX_W:0]        fill_cnt;
  logic [IDX_W-1:0]      lane_sel;
  logic [RATIO-1:0]      fill_mask;
  logic                  emit_full, emit_partial, emit;

  logic [DO_WIDTH-1:0]   data_out_q;
  logic                  dout_vd_q;
  logic [RATIO-1:0]      dout_mask_q;
  logic [WORD_CNT_W-1:0] word_cnt_q;

  // Physical lane for the incoming sample and the lanes occupied after it lands.
  always_comb begin
    fill_cnt  = {1'b0, idx_q} + (IDX_W+1)'(din_vd);
    fill_mask = '0;
`ifdef DATA_FORMAT_IN_MSB_FIRST_EN
    lane_sel = LAST_IDX - idx_q;
    for (int i = 0; i < RATIO; i++) begin
      fill_mask[i] = ((RATIO - 1 - i) < int'(fill_cnt));
    end
`else
    lane_sel = idx_q;
    for (int i = 0; i < RATIO; i++) begin
      fill_mask[i] = (i < int'(fill_cnt));
    end
`endif
  end

  // Accumulator contents with the current sample written in (if any).
  always_comb begin
    acc_fill = acc_q;
    for (int i = 0; i < RATIO; i++) begin
      if (din_vd && (lane_sel == IDX_W'(i))) begin
        acc_fill[i*DI_WIDTH +: DI_WIDTH] = data_in;
      end
    end
  end

  // Next-state logic: a sample filling the last lane wins over flush, so a
  // flush coinciding with the final sample yields exactly one full word.
  always_comb begin
    state_next   = state_q;
    idx_next     = idx_q;
    acc_next     = acc_q;
    emit_full    = din_vd && (idx_q == LAST_IDX);
    emit_partial = flush && !emit_full && ((state_q == ST_FILLING) || din_vd);
    emit         = emit_full || emit_partial;
    if (emit) begin
      state_next = ST_EMPTY;
      idx_next   = '0;
      acc_next   = '0;
    end else if (din_vd) begin
      state_next = ST_FILLING;
      idx_next   = idx_q + 1'b1;
      acc_next   = acc_fill;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_next;
    end
  end

  // Lane index and accumulator; a partial word held at reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_next;
      acc_q <= acc_next;
    end
  end

  // Output word register; data and mask hold between valid words.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= '0;
      dout_vd_q   <= 1'b0;
      dout_mask_q <= '0;
    end else begin
      dout_vd_q <= emit;
      if (emit) begin
        data_out_q  <= acc_fill;
        dout_mask_q <= fill_mask;
      end
    end
  end

  // Emitted-word counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_q <= '0;
    end else if (emit) begin
      word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  assign data_out  = data_out_q;
  assign dout_vd   = dout_vd_q;
  assign dout_mask = dout_mask_q;
  assign word_cnt  = word_cnt_q;
  assign busy      = (state_q == ST_FILLING);

endmodule

// File: tb/tb_data_format_in.sv
// Directed bench for data_format_in (default 32->64 configuration).
// Expected lane placement follows DATA_FORMAT_IN_MSB_FIRST_EN when defined.
module tb_data_format_in;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        din_vd;
  logic        flush;
  logic [63:0] data_out;
  logic        dout_vd;
  logic [1:0]  dout_mask;
  logic [31:0] word_cnt;
  logic        busy;

  int n_checks;
  int n_fail;

  data_format_in dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .din_vd    (din_vd),
    .flush     (flush),
    .data_out  (data_out),
    .dout_vd   (dout_vd),
    .dout_mask (dout_mask),
    .word_cnt  (word_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected packed word from first/second sample of a word.
  function automatic logic [63:0] pack2(input logic [31:0] first, input logic [31:0] second);
`ifdef DATA_FORMAT_IN_MSB_FIRST_EN
    return {first, second};
`else
    return {second, first};
`endif
  endfunction

  // Expected partial word holding only the first sample.
  function automatic logic [63:0] pack1(input logic [31:0] first);
`ifdef DATA_FORMAT_IN_MSB_FIRST_EN
    return {first, 32'h0};
`else
    return {32'h0, first};
`endif
  endfunction

`ifdef DATA_FORMAT_IN_MSB_FIRST_EN
  localparam logic [1:0] MASK_ONE = 2'b10;
`else
  localparam logic [1:0] MASK_ONE = 2'b01;
`endif

  task automatic sample(input logic [31:0] d, input logic f);
    data_in = d;
    din_vd  = 1'b1;
    flush   = f;
    tick();
    din_vd  = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    data_in  = '0;
    din_vd   = 1'b0;
    flush    = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_data", data_out, 64'h0);
    chk("rst_vd", {63'h0, dout_vd}, 64'h0);
    chk("rst_mask", {62'h0, dout_mask}, 64'h0);
    chk("rst_cnt", {32'h0, word_cnt}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    reset = 1'b0;
    tick();

    // Test 1: two samples -> one full word
    sample(32'h1111_1111, 1'b0);
    chk("t1_busy", {63'h0, busy}, 64'h1);
    chk("t1_vd0", {63'h0, dout_vd}, 64'h0);
    sample(32'h2222_2222, 1'b0);
    chk("t1_vd", {63'h0, dout_vd}, 64'h1);
    chk("t1_data", data_out, pack2(32'h1111_1111, 32'h2222_2222));
    chk("t1_mask", {62'h0, dout_mask}, 64'h3);
    chk("t1_cnt", {32'h0, word_cnt}, 64'd1);
    chk("t1_busy_lo", {63'h0, busy}, 64'h0);
    tick();
    chk("t1_vd_drop", {63'h0, dout_vd}, 64'h0);
    chk("t1_hold", data_out, pack2(32'h1111_1111, 32'h2222_2222));

    // Test 2: eight back-to-back samples -> four words
    for (int k = 0; k < 8; k++) begin
      data_in = 32'h100 + 32'(k);
      din_vd  = 1'b1;
      tick();
      chk($sformatf("t2_vd%0d", k), {63'h0, dout_vd}, {63'h0, 1'(k % 2)});
      if (k % 2 == 1) begin
        chk($sformatf("t2_data%0d", k), data_out,
            pack2(32'h100 + 32'(k - 1), 32'h100 + 32'(k)));
      end
    end
    din_vd = 1'b0;
    tick();
    chk("t2_cnt", {32'h0, word_cnt}, 64'd5);

    // Test 3: single sample then flush alone
    sample(32'hAAAA_5555, 1'b0);
    chk("t3_busy_hi", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_vd", {63'h0, dout_vd}, 64'h1);
    chk("t3_data", data_out, pack1(32'hAAAA_5555));
    chk("t3_mask", {62'h0, dout_mask}, {62'h0, MASK_ONE});
    chk("t3_busy_lo", {63'h0, busy}, 64'h0);
    chk("t3_cnt", {32'h0, word_cnt}, 64'd6);

    // Test 4: flush with the completing sample, then flush while empty
    sample(32'h0BAD_0001, 1'b0);
    sample(32'hBEEF_0002, 1'b1);
    chk("t4_vd", {63'h0, dout_vd}, 64'h1);
    chk("t4_data", data_out, pack2(32'h0BAD_0001, 32'hBEEF_0002));
    chk("t4_mask", {62'h0, dout_mask}, 64'h3);
    flush = 1'b1;
    tick();
    chk("t4_no_extra", {63'h0, dout_vd}, 64'h0);
    tick();
    flush = 1'b0;
    chk("t4_empty_flush", {63'h0, dout_vd}, 64'h0);
    chk("t4_busy", {63'h0, busy}, 64'h0);
    chk("t4_cnt", {32'h0, word_cnt}, 64'd7);

    // Flush together with the first sample of a word -> one-lane partial word
    sample(32'h5A5A_0003, 1'b1);
    chk("t4b_vd", {63'h0, dout_vd}, 64'h1);
    chk("t4b_data", data_out, pack1(32'h5A5A_0003));
    chk("t4b_mask", {62'h0, dout_mask}, {62'h0, MASK_ONE});
    chk("t4b_busy", {63'h0, busy}, 64'h0);

    // Test 5: reset while filling drops the held lane
    sample(32'hDEAD_DEAD, 1'b0);
    chk("t5_busy", {63'h0, busy}, 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_data", data_out, 64'h0);
    chk("t5_rst_cnt", {32'h0, word_cnt}, 64'h0);
    chk("t5_rst_busy", {63'h0, busy}, 64'h0);
    chk("t5_rst_mask", {62'h0, dout_mask}, 64'h0);
    sample(32'h0000_0001, 1'b0);
    sample(32'h0000_0002, 1'b0);
    chk("t5_vd", {63'h0, dout_vd}, 64'h1);
    chk("t5_data", data_out, pack2(32'h0000_0001, 32'h0000_0002));
    chk("t5_cnt", {32'h0, word_cnt}, 64'd1);

    // Test 6: word counter wrap
    @(negedge clk);
    force dut.word_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.word_cnt_q;
    #1;
    chk("t6_preload", {32'h0, word_cnt}, 64'hFFFF_FFFF);
    sample(32'h3333_3333, 1'b0);
    sample(32'h4444_4444, 1'b0);
    chk("t6_vd", {63'h0, dout_vd}, 64'h1);
    chk("t6_data", data_out, pack2(32'h3333_3333, 32'h4444_4444));
    chk("t6_wrap", {32'h0, word_cnt}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
